// File: rtl/ttt_tick_scheduler_pkg.sv
// rtl/ttt_tick_scheduler_pkg.sv - shared widths, saturation constant and saturating add
// Purpose: default widths for the tick scheduler, the saturation ceiling of the
//          token accumulators and a width-generic saturating adder.
// Ports:   none (package).
package ttt_sched_pkg;

  localparam int NUM_REQ_DEF         = 4;
  localparam int NEW_TOKENS_BITS_DEF = 4;
  localparam int TOKENS_BITS_DEF     = 4;
  localparam int DURATION_BITS_DEF   = 4;
  localparam int PRESCALE_BITS_DEF   = 8;

  localparam int unsigned SAT_MAX = (1 << NEW_TOKENS_BITS_DEF) - 1;

  // Adds two operands that each fit in 'bits' bits and clips the result at
  // 2^bits-1. The sum is formed wide, so the carry out of 'bits' is never lost.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned bits,
                                          output logic       sat);
    logic [31:0] sum;
    logic [31:0] max;
    sum = a + b;
    max = (32'd1 << bits) - 32'd1;
    sat = (sum > max);
    return sat ? max : sum;
  endfunction

endpackage

// File: rtl/ttt_tick_scheduler_if.sv
// rtl/ttt_tick_scheduler_if.sv - token requester bus between requesters and scheduler
// Purpose: bundles the per-requester valid/increment signals and the one-hot grant.
// Ports:   req_valid (NUM_REQ), req_good/req_bad (NUM_REQ*NEW_TOKENS_BITS, slice i
//          belongs to requester i), req_ready (NUM_REQ one-hot grant).
//          master = requester side, slave = scheduler side.
interface ttt_tick_scheduler_if
  import ttt_sched_pkg::*;
#(
  parameter int NUM_REQ         = NUM_REQ_DEF,
  parameter int NEW_TOKENS_BITS = NEW_TOKENS_BITS_DEF
);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ*NEW_TOKENS_BITS-1:0] req_good;
  logic [NUM_REQ*NEW_TOKENS_BITS-1:0] req_bad;
  logic [NUM_REQ-1:0]                 req_ready;

  modport master (output req_valid, output req_good, output req_bad, input req_ready);
  modport slave  (input req_valid, input req_good, input req_bad, output req_ready);

endinterface

// File: rtl/ttt_tick_scheduler_rr_arbiter.sv
// rtl/ttt_tick_scheduler_rr_arbiter.sv - rotating-priority arbiter with one-hot grant
// Purpose: grants one requesting index per enabled cycle, searching upward from a
//          pointer with wrap-around; the pointer moves past the winner.
// Ports:   clk, reset (sync active-high), en (grant allowed), req[N] (requests),
//          grant[N] (combinational one-hot grant, 0 when en=0 or no request).
module ttt_rr_arbiter
  import ttt_sched_pkg::*;
#(
  parameter int N = NUM_REQ_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    ptr_d = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = (idx == N - 1) ? PW'(0) : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ttt_tick_scheduler.sv
// rtl/ttt_tick_scheduler.sv - prescaled tick generator with arbitrated token accumulation
// Purpose: divides clk into a one-cycle tick, accumulates good/bad token increments
//          granted by a round-robin arbiter into saturating window totals, and
//          presents those totals plus shadowed configuration to the core on tick.
// Ports:   clk, reset (sync active-high), enable (freeze when low), prescale (period-1),
//          req (requester bus, slave side), cfg_good_thr/cfg_bad_thr/cfg_duration
//          (staged config), tick, new_good_tokens/new_bad_tokens (window totals, 0
//          off-tick), good_thr/bad_thr/duration (shadowed config), overflow.
module ttt_tick_scheduler
  import ttt_sched_pkg::*;
#(
  parameter int NUM_REQ         = NUM_REQ_DEF,
  parameter int NEW_TOKENS_BITS = NEW_TOKENS_BITS_DEF,
  parameter int TOKENS_BITS     = TOKENS_BITS_DEF,
  parameter int DURATION_BITS   = DURATION_BITS_DEF,
  parameter int PRESCALE_BITS   = PRESCALE_BITS_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [PRESCALE_BITS-1:0]   prescale,
  ttt_tick_scheduler_if.slave        req,
  input  logic [TOKENS_BITS-1:0]     cfg_good_thr,
  input  logic [TOKENS_BITS-1:0]     cfg_bad_thr,
  input  logic [DURATION_BITS-1:0]   cfg_duration,
  output logic                       tick,
  output logic [NEW_TOKENS_BITS-1:0] new_good_tokens,
  output logic [NEW_TOKENS_BITS-1:0] new_bad_tokens,
  output logic [TOKENS_BITS-1:0]     good_thr,
  output logic [TOKENS_BITS-1:0]     bad_thr,
  output logic [DURATION_BITS-1:0]   duration,
  output logic                       overflow
);

  localparam int NTB = NEW_TOKENS_BITS;

  logic [NUM_REQ-1:0]       grant;
  logic [PRESCALE_BITS-1:0] cnt_q, cnt_d;
  logic [NTB-1:0]           acc_good_q, acc_good_d;
  logic [NTB-1:0]           acc_bad_q, acc_bad_d;
  logic                     sat_q, sat_d;
  logic                     tick_q, tick_d;
  logic [NTB-1:0]           new_good_q, new_good_d;
  logic [NTB-1:0]           new_bad_q, new_bad_d;
  logic                     overflow_q, overflow_d;
  logic [TOKENS_BITS-1:0]   good_thr_q, good_thr_d;
  logic [TOKENS_BITS-1:0]   bad_thr_q, bad_thr_d;
  logic [DURATION_BITS-1:0] duration_q, duration_d;

  logic                     terminal;
  logic                     xfer;
  logic [NTB-1:0]           inc_good, inc_bad;
  logic [31:0]              good_sum, bad_sum;
  logic                     good_sat, bad_sat;
  logic [NTB-1:0]           acc_good_nx, acc_bad_nx;
  logic                     sat_nx;
  logic                     unused_sum_hi;

  ttt_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (enable),
    .req   (req.req_valid),
    .grant (grant)
  );

  assign req.req_ready = grant;

  // Grant is already gated by enable and by valid, so any grant bit is a transfer.
  always_comb begin
    inc_good = '0;
    inc_bad  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        inc_good = inc_good | req.req_good[i*NTB +: NTB];
        inc_bad  = inc_bad  | req.req_bad[i*NTB +: NTB];
      end
    end
  end

  assign xfer     = |(req.req_valid & grant);
  assign terminal = enable && (cnt_q == prescale);

  always_comb begin
    good_sat = 1'b0;
    bad_sat  = 1'b0;
    good_sum = sat_add(32'(acc_good_q), 32'(inc_good), NTB, good_sat);
    bad_sum  = sat_add(32'(acc_bad_q),  32'(inc_bad),  NTB, bad_sat);
  end

  assign unused_sum_hi = ^{good_sum[31:NTB], bad_sum[31:NTB]};

  // Window state as it stands after this cycle's transfer, so a transfer in the
  // terminal cycle lands in the closing window.
  assign acc_good_nx = xfer ? good_sum[NTB-1:0] : acc_good_q;
  assign acc_bad_nx  = xfer ? bad_sum[NTB-1:0]  : acc_bad_q;
  assign sat_nx      = sat_q | (xfer & (good_sat | bad_sat));

  always_comb begin
    cnt_d      = cnt_q;
    acc_good_d = acc_good_nx;
    acc_bad_d  = acc_bad_nx;
    sat_d      = sat_nx;
    tick_d     = 1'b0;
    new_good_d = '0;
    new_bad_d  = '0;
    overflow_d = 1'b0;
    good_thr_d = good_thr_q;
    bad_thr_d  = bad_thr_q;
    duration_d = duration_q;

    // Counter wraps naturally at 2^PRESCALE_BITS if prescale drops below it.
    if (enable) cnt_d = cnt_q + 1'b1;

    if (terminal) begin
      cnt_d      = '0;
      tick_d     = 1'b1;
      new_good_d = acc_good_nx;
      new_bad_d  = acc_bad_nx;
      overflow_d = sat_nx;
      good_thr_d = cfg_good_thr;
      bad_thr_d  = cfg_bad_thr;
      duration_d = cfg_duration;
      acc_good_d = '0;
      acc_bad_d  = '0;
      sat_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_good_q <= '0;
      acc_bad_q  <= '0;
      sat_q      <= 1'b0;
      tick_q     <= 1'b0;
      new_good_q <= '0;
      new_bad_q  <= '0;
      overflow_q <= 1'b0;
      good_thr_q <= '0;
      bad_thr_q  <= '0;
      duration_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      acc_good_q <= acc_good_d;
      acc_bad_q  <= acc_bad_d;
      sat_q      <= sat_d;
      tick_q     <= tick_d;
      new_good_q <= new_good_d;
      new_bad_q  <= new_bad_d;
      overflow_q <= overflow_d;
      good_thr_q <= good_thr_d;
      bad_thr_q  <= bad_thr_d;
      duration_q <= duration_d;
    end
  end

  assign tick            = tick_q;
  assign new_good_tokens = new_good_q;
  assign new_bad_tokens  = new_bad_q;
  assign overflow        = overflow_q;
  assign good_thr        = good_thr_q;
  assign bad_thr         = bad_thr_q;
  assign duration        = duration_q;

endmodule

// File: tb/tb_ttt_tick_scheduler.sv
// tb/tb_ttt_tick_scheduler.sv - directed self-checking bench for ttt_tick_scheduler
module tb_ttt_tick_scheduler;
  import ttt_sched_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] prescale;
  logic [3:0] cfg_good_thr, cfg_bad_thr, cfg_duration;
  logic       tick, overflow;
  logic [3:0] new_good_tokens, new_bad_tokens, good_thr, bad_thr, duration;

  int tests_run    = 0;
  int tests_failed = 0;

  ttt_tick_scheduler_if #(.NUM_REQ(4), .NEW_TOKENS_BITS(4)) rq ();

  ttt_tick_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .prescale        (prescale),
    .req             (rq.slave),
    .cfg_good_thr    (cfg_good_thr),
    .cfg_bad_thr     (cfg_bad_thr),
    .cfg_duration    (cfg_duration),
    .tick            (tick),
    .new_good_tokens (new_good_tokens),
    .new_bad_tokens  (new_bad_tokens),
    .good_thr        (good_thr),
    .bad_thr         (bad_thr),
    .duration        (duration),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_req(input int idx, input int g, input int b);
    rq.req_good[idx*4 +: 4] = 4'(g);
    rq.req_bad[idx*4 +: 4]  = 4'(b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycn(2);
    reset        = 1'b0;
    enable       = 1'b0;
    rq.req_valid = '0;
    rq.req_good  = '0;
    rq.req_bad   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests_run);
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    prescale     = 8'd0;
    cfg_good_thr = 4'd7;
    cfg_bad_thr  = 4'd7;
    cfg_duration = 4'd7;
    rq.req_valid = 4'b1111;
    rq.req_good  = 16'h1111;
    rq.req_bad   = 16'h1111;

    // Reset state: reset wins over an enabled prescale=0 with live requests.
    do_reset();
    check("rst_tick", tick, 0);
    check("rst_good", new_good_tokens, 0);
    check("rst_ovf", overflow, 0);
    check("rst_gthr", good_thr, 0);
    check("rst_dur", duration, 0);

    // A: prescale=3, no requests -> tick every 4th edge.
    cfg_good_thr = 4'd0; cfg_bad_thr = 4'd0; cfg_duration = 4'd0;
    prescale = 8'd3; enable = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      check($sformatf("a_tick%0d", n), tick, (n % 4 == 0) ? 1 : 0);
      if (n % 4 == 0) begin
        check("a_good", new_good_tokens, 0);
        check("a_ovf", overflow, 0);
        check("a_gthr", good_thr, 0);
      end
    end

    // B: prescale=7, requester 1 (3/1) twice, requester 2 (2/0) once.
    do_reset();
    prescale = 8'd7; enable = 1'b1;
    set_req(1, 3, 1); set_req(2, 2, 0);
    rq.req_valid = 4'b0110;
    #1 check("b_rdy1", rq.req_ready, 4'b0010);
    cyc();
    check("b_rdy2", rq.req_ready, 4'b0100);
    cyc();
    rq.req_valid = 4'b0010;
    #1 check("b_rdy3", rq.req_ready, 4'b0010);
    cyc();
    rq.req_valid = 4'b0000;
    cycn(4);
    check("b_notick7", tick, 0);
    cyc();
    check("b_tick", tick, 1);
    check("b_good", new_good_tokens, 8);
    check("b_bad", new_bad_tokens, 2);
    check("b_ovf", overflow, 0);
    cyc();
    check("b_after_tick", tick, 0);
    check("b_after_good", new_good_tokens, 0);
    cycn(7);
    check("b_tick2", tick, 1);
    check("b_good2", new_good_tokens, 0);

    // C: all four valid with good=1, prescale=15 -> rotating grants, saturation.
    do_reset();
    prescale = 8'd15; enable = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1, 0);
    rq.req_valid = 4'b1111;
    #1 check("c_g0", rq.req_ready, 4'b0001);
    cyc(); check("c_g1", rq.req_ready, 4'b0010);
    cyc(); check("c_g2", rq.req_ready, 4'b0100);
    cyc(); check("c_g3", rq.req_ready, 4'b1000);
    cyc(); check("c_g4", rq.req_ready, 4'b0001);
    cycn(12);
    check("c_tick", tick, 1);
    check("c_good", new_good_tokens, 15);
    check("c_bad", new_bad_tokens, 0);
    check("c_ovf", overflow, 1);
    rq.req_valid = 4'b0000;
    cyc();
    check("c_ovf_clr", overflow, 0);

    // D: transfer in the terminal cycle lands in the closing window.
    do_reset();
    prescale = 8'd3; enable = 1'b1;
    cycn(3);
    set_req(0, 5, 0);
    rq.req_valid = 4'b0001;
    cyc();
    rq.req_valid = 4'b0000;
    check("d_tick", tick, 1);
    check("d_good", new_good_tokens, 5);
    cycn(4);
    check("d_tick2", tick, 1);
    check("d_good2", new_good_tokens, 0);

    // E: staged config only becomes visible on tick.
    do_reset();
    prescale = 8'd3; enable = 1'b1;
    cfg_good_thr = 4'd2; cfg_bad_thr = 4'd5; cfg_duration = 4'd11;
    cycn(4);
    check("e_gthr_a", good_thr, 2);
    check("e_bthr", bad_thr, 5);
    check("e_dur", duration, 11);
    cyc();
    cfg_good_thr = 4'd9;
    cyc(); check("e_hold6", good_thr, 2);
    cyc(); check("e_hold7", good_thr, 2);
    cyc(); check("e_gthr_b", good_thr, 9);

    // F: reset mid-window discards pending totals.
    do_reset();
    prescale = 8'd7; enable = 1'b1;
    set_req(0, 6, 0);
    rq.req_valid = 4'b0001;
    cyc();
    rq.req_valid = 4'b0000;
    cycn(4);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    set_req(3, 2, 0);
    rq.req_valid = 4'b1000;
    #1 check("f_rdy", rq.req_ready, 4'b1000);
    cyc();
    rq.req_valid = 4'b0000;
    check("f_notick1", tick, 0);
    for (int n = 2; n <= 7; n++) begin
      cyc();
      check($sformatf("f_notick%0d", n), tick, 0);
    end
    cyc();
    check("f_tick", tick, 1);
    check("f_good", new_good_tokens, 2);

    // G: enable low for 10 cycles stretches the period and blocks grants.
    do_reset();
    prescale = 8'd3; enable = 1'b1;
    cycn(2);
    enable = 1'b0;
    rq.req_valid = 4'b1111;
    for (int n = 0; n < 10; n++) begin
      #1 check($sformatf("g_rdy%0d", n), rq.req_ready, 0);
      cyc();
      check($sformatf("g_tick%0d", n), tick, 0);
    end
    enable = 1'b1;
    rq.req_valid = 4'b0000;
    cyc();
    check("g_pre_tick", tick, 0);
    cyc();
    check("g_tick", tick, 1);
    check("g_good", new_good_tokens, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ttt_tick_scheduler.md
Name: ttt_tick_scheduler

Overview:
- Sequences the token processor core from a single fast clock.
- A programmable prescaler generates the slow "tick" on which the core advances one step.
- Between ticks, a round-robin arbiter collects good/bad token increments from NUM_REQ requesters into saturating accumulators. Each tick delivers the window totals to the core's new_good_tokens/new_bad_tokens inputs.
- Threshold and duration configuration is shadowed, so the core only sees new values at tick boundaries.

Parameters:
- NUM_REQ, 4, number of token requesters (>=2).
- NEW_TOKENS_BITS, 4, width of each increment and of each accumulated total.
- TOKENS_BITS, 4, width of the threshold outputs.
- DURATION_BITS, 4, width of the duration output.
- PRESCALE_BITS, 8, width of the prescaler compare value.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run; when low, prescaler, arbiter and accumulators freeze.
- prescale  in  PRESCALE_BITS  tick period minus one, in clk cycles.
- req_valid  in  NUM_REQ  per-requester increment valid.
- req_good  in  NUM_REQ*NEW_TOKENS_BITS  good increment; requester i occupies slice i.
- req_bad  in  NUM_REQ*NEW_TOKENS_BITS  bad increment; requester i occupies slice i.
- req_ready  out  NUM_REQ  one-hot grant (combinational); transfer = valid & ready.
- cfg_good_thr  in  TOKENS_BITS  staged good threshold.
- cfg_bad_thr  in  TOKENS_BITS  staged bad threshold.
- cfg_duration  in  DURATION_BITS  staged duration.
- tick  out  1  one-cycle strobe; the core advances on this cycle.
- new_good_tokens  out  NEW_TOKENS_BITS  window good total; valid only while tick=1, 0 otherwise.
- new_bad_tokens  out  NEW_TOKENS_BITS  window bad total; valid only while tick=1, 0 otherwise.
- good_thr  out  TOKENS_BITS  shadowed threshold to the core.
- bad_thr  out  TOKENS_BITS  shadowed threshold to the core.
- duration  out  DURATION_BITS  shadowed duration to the core.
- overflow  out  1  registered with tick; 1 if either accumulator saturated in that window.

Behaviour:
- Reset clears the following to 0:
  - prescaler counter, accumulators, saturation flags;
  - round-robin pointer;
  - tick, new_good_tokens, new_bad_tokens, overflow;
  - good_thr, bad_thr, duration.
- Prescaler:
  - The counter increments while enable=1.
  - Terminal cycle: counter==prescale and enable=1. On that cycle the counter returns to 0.
  - prescale=0 makes every enabled cycle terminal.
  - If prescale is lowered below the current count, the counter wraps at 2^PRESCALE_BITS and then matches normally.
- tick is registered: it is 1 in the cycle after each terminal cycle, for exactly one cycle.
- Arbiter:
  - Each cycle with enable=1, exactly one valid requester is granted. Selection starts at the pointer and searches upward with wrap-around.
  - After a grant, the pointer moves to the granted index + 1, modulo NUM_REQ.
  - No valid requesters: no grant, pointer holds.
  - enable=0: req_ready=0.
  - An ungranted requester holds valid and data. The arbiter imposes no other ordering.
- Accumulation:
  - On a transfer, acc_good = min(acc_good + req_good[i], 2^NEW_TOKENS_BITS - 1). acc_bad is handled identically.
  - The sum is computed at NEW_TOKENS_BITS+1 bits.
  - Saturation sets the window's sat flag.
- Terminal cycle:
  - A transfer accepted in the terminal cycle is included in the closing window.
  - The next-edge registers take the following values:
    - new_good_tokens/new_bad_tokens ← accumulated values including that transfer;
    - overflow ← sat flag, including that transfer;
    - good_thr/bad_thr/duration ← cfg_* sampled in the terminal cycle.
  - Accumulators and sat flags clear to 0 on the same edge.
- Non-tick cycles: new_* = 0, overflow = 0, shadow outputs hold.
- Reset mid-window discards pending totals; no tick is emitted for the discarded window.
- enable deasserted mid-window: the counter and accumulators hold and the window resumes on re-enable. Any tick already registered still completes.

Decomposition:
- Package ttt_sched_pkg holds:
  - default width localparams;
  - the saturation max constant, (1<<NEW_TOKENS_BITS)-1;
  - a saturating-add function.
- Sub-module ttt_rr_arbiter (parameter N): inputs clk, reset, en, req[N]; outputs grant[N] one-hot. It contains the rotating-priority pointer.
- Prescaler, accumulators and shadow registers stay in the top module.

Test Plan:
- Reset, prescale=3, enable=1, no requests → tick on cycles 4, 8, 12…; new_*=0; overflow=0; shadows=0.
- prescale=7; requester 1 sends good=3/bad=1 twice; requester 2 sends good=2 → at tick, new_good_tokens=8, new_bad_tokens=2, overflow=0; next window reads 0.
- All 4 requesters valid continuously, each with good=1 → grants cycle 0,1,2,3,0…; with prescale=15, 16 transfers exceed the saturation value 15, so new_good_tokens=15 and overflow=1.
- Transfer of good=5 in the terminal cycle → included in the current tick (new_good_tokens=5); next window starts at 0.
- cfg_good_thr changes 2→9 mid-window → good_thr stays 2 until the tick cycle, then reads 9.
- reset asserted with acc_good=6 → no tick for that window; the next tick after reset reports only post-reset transfers. enable=0 for 10 cycles → tick period stretches by 10 and req_ready=0 throughout.
